sprite_plotter: RTL
===================

// Module: sprite_plotter
// PURPOSE
// - Draw engine that answers the game FSM's draw commands (item, erase, position) and drives the
//   vga_adapter plot interface with one pixel per clock.
// - Sits between the game FSM and the vga_adapter: game FSM = initiator, sprite_plotter = responder.
// - Explicit req/busy/done handshake replaces fixed-delay waiting.
//   A full sprite finishes well inside the game's 2401-cycle slot.
// PARAMETERS
// - PRESS_W  20  press sprite width, pixels (1..32)
// - PRESS_H  20  press sprite height, pixels (1..32)
// - GARB_W   10  garbage sprite width, pixels (1..32)
// - GARB_H   10  garbage sprite height, pixels (1..32)
// PORTS
// - CLOCK_50  in   1  system clock, 50 MHz; all state on posedge
// - reset_n   in   1  reset, asynchronous, active-low
// - req       in   1  command valid; accepted only when busy=0
// - item      in   1  1 = press sprite, 0 = garbage sprite
// - erase     in   1  1 = paint the sprite footprint black
// - position  in   3  slot index: press 0..5, garbage 0..3
// - busy      out  1  high from the cycle after accept until done
// - done      out  1  one-cycle pulse when the command completes
// - x         out  8  pixel column, 0..159
// - y         out  7  pixel row, 0..119
// - colour    out  3  RGB pixel colour {R,G,B}
// - plot      out  1  write strobe to vga_adapter
// BEHAVIOUR
// - Reset (async): state=IDLE; busy, done and plot = 0; x, y and colour = 0.
//   Asserting reset mid-draw stops plot in the same instant; no pixel is emitted after reset.
// - States: IDLE -> (req & valid position) DRAW -> LAST -> DONE -> IDLE.
//   IDLE -> (req & invalid position) DONE -> IDLE.
// - Accept cycle (IDLE & req): latch item, erase, position and the origin (ox,oy) from the LUT;
//   clear the scan counters (cx=0, cy=0).
// - DRAW: each cycle drive plot=1, x=ox+cx, y=oy+cy.
//   cx increments and wraps to 0 at W-1; cy then increments.
//   The pixel (W-1,H-1) moves to LAST.
// - LAST: emits the final pixel. In DONE, plot=0 and done=1 for exactly one cycle.
// - Latency: first plot one cycle after accept; W*H plot cycles total; done on the cycle after the
//   last plot. Default press = 400 plots; default garbage = 100 plots.
// - Colour:
//   - erase=1: 3'b000 for every pixel.
//   - press: border pixels (cx==0 | cx==W-1 | cy==0 | cy==H-1) = 3'b111; interior = 3'b100.
//   - garbage: solid 3'b010.
// - Invalid position: press with position > 5, or garbage with position > 3
//   (garbage 3'b111 means "no garbage").
//   The command is accepted, zero pixels are plotted, and done pulses one cycle after accept.
// - req while busy, or while in DONE, is ignored; it is not queued.
//   req held high in IDLE after DONE starts a new command.
// - Arithmetic: x=ox+cx and y=oy+cy computed 8-bit; the LUT guarantees no overflow past 159/119.
//   Width parameters above 32 are illegal.
// - Outputs x, y, colour and plot are registered; done is registered.
// STRUCTURE
// - project_pkg:
//   - colour constants BLACK=3'b000, WHITE=3'b111, RED=3'b100, GREEN=3'b010;
//   - state enum;
//   - origin tables PRESS_X[0:5] = {10,35,60,85,110,135}, PRESS_Y = 20;
//   - GARB_X[0:3] = {15,40,65,90}, GARB_Y = 90.
// - One sub-module, pixel_scanner: cx/cy counters with clear, step and wrap at W/H;
//   outputs cx, cy, is_last and is_border.
// - The top of sprite_plotter holds the FSM, command latch, origin LUT and colour mux.
// TESTING
// - Reset, then req, item=1, erase=0, position=0:
//   - first plot at (10,20) colour 111, one cycle after accept;
//   - 400 plots, last at (29,39);
//   - interior (11,21) = 100; done one cycle after (29,39); busy low after done.
// - item=0, erase=0, position=3:
//   - 100 plots, all colour 010, spanning x 90..99 and y 90..99; then a single done pulse.
// - item=1, erase=1, position=5: 400 plots with x 135..154 and y 20..39, every colour 000.
// - item=0, position=7 (no garbage): zero plots, done pulses on the cycle after accept.
// - Second req pulsed mid-draw: ignored; exactly one done per accepted command.
// - Reset asserted at plot #50 of a press draw:
//   - plot, busy and done drop immediately;
//   - after release, a fresh command draws a full 400 plots.

Source files
------------

// File: rtl/sprite_plotter_pkg.sv
// sprite_plotter_pkg: colours, FSM states and slot origin tables for the sprite draw engine
package sprite_plotter_pkg;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] GREEN = 3'b010;

   typedef enum logic [1:0] {IDLE, DRAW, LAST, DONE} state_t;

   localparam logic [7:0] PRESS_X [0:5] = '{8'd10, 8'd35, 8'd60, 8'd85, 8'd110, 8'd135};
   localparam logic [6:0] PRESS_Y       = 7'd20;
   localparam logic [7:0] GARB_X  [0:3] = '{8'd15, 8'd40, 8'd65, 8'd90};
   localparam logic [6:0] GARB_Y        = 7'd90;

   function automatic logic pos_valid(input logic itm, input logic [2:0] p);
      return itm ? p <= 3'd5 : p <= 3'd3;
   endfunction

   function automatic logic [7:0] origin_x(input logic itm, input logic [2:0] p);
      return itm ? (p > 3'd5 ? 8'd0 : PRESS_X[p]) : GARB_X[p[1:0]];
   endfunction

   function automatic logic [6:0] origin_y(input logic itm);
      return itm ? PRESS_Y : GARB_Y;
   endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// sprite_plotter_if: draw command handshake from the game FSM plus the vga_adapter plot bus
interface sprite_plotter_if;
   logic       req;
   logic       item;
   logic       erase;
   logic [2:0] position;
   logic       busy;
   logic       done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   modport master (output req, item, erase, position, input busy, done, x, y, colour, plot);
   modport slave  (input req, item, erase, position, output busy, done, x, y, colour, plot);
endinterface

// File: rtl/sprite_plotter_pixel_scanner.sv
// pixel_scanner: raster counters; cx/cy present the coordinate being loaded this cycle
module pixel_scanner (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       clr,
   input  logic       step,
   input  logic [4:0] wm,
   input  logic [4:0] hm,
   output logic [4:0] cx,
   output logic [4:0] cy,
   output logic       is_last,
   output logic       is_border
);
   logic [4:0] rx, ry;

   // next coordinate and its classification, so outputs register in step with the FSM
   always_comb begin
      cx = clr ? 5'd0 : step ? (rx == wm ? 5'd0 : rx + 5'd1) : rx;
      cy = clr ? 5'd0 : (step && rx == wm) ? ry + 5'd1 : ry;
      is_last = cx == wm && cy == hm;
      is_border = cx == 5'd0 || cx == wm || cy == 5'd0 || cy == hm;
   end

   // counter state
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) {rx, ry} <= '0;
      else {rx, ry} <= {cx, cy};
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: answers draw commands by streaming one sprite pixel per clock to the vga_adapter
module sprite_plotter
   import sprite_plotter_pkg::*;
#(
   parameter int PRESS_W = 20,
   parameter int PRESS_H = 20,
   parameter int GARB_W  = 10,
   parameter int GARB_H  = 10
) (
   input logic CLOCK_50,
   input logic reset_n,
   sprite_plotter_if.slave bus
);
   localparam logic [4:0] PWM = 5'(PRESS_W - 1);
   localparam logic [4:0] PHM = 5'(PRESS_H - 1);
   localparam logic [4:0] GWM = 5'(GARB_W - 1);
   localparam logic [4:0] GHM = 5'(GARB_H - 1);

   state_t     state, state_n;
   logic       it, er, s_it, s_er, idle, step, is_last, is_border, drawing;
   logic [7:0] ox, s_ox, nx;
   logic [6:0] oy, s_oy, ny;
   logic [4:0] cx, cy, wm, hm;
   logic [2:0] col;

   // in IDLE the incoming command is used directly so the first pixel loads on the accept edge
   always_comb begin
      idle = state == IDLE;
      s_it = idle ? bus.item : it;
      s_er = idle ? bus.erase : er;
      s_ox = idle ? origin_x(bus.item, bus.position) : ox;
      s_oy = idle ? origin_y(bus.item) : oy;
      wm = s_it ? PWM : GWM;
      hm = s_it ? PHM : GHM;
      step = state == DRAW;
      state_n = idle ? (bus.req ? (pos_valid(bus.item, bus.position) ? (is_last ? LAST : DRAW) : DONE) : IDLE)
              : step ? (is_last ? LAST : DRAW)
              : state == LAST ? DONE : IDLE;
      drawing = state_n == DRAW || state_n == LAST;
      nx = s_ox + {3'd0, cx};
      ny = s_oy + {2'd0, cy};
      col = s_er ? BLACK : s_it ? (is_border ? WHITE : RED) : GREEN;
   end

   pixel_scanner u_scan (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .clr      (idle),
      .step     (step),
      .wm       (wm),
      .hm       (hm),
      .cx       (cx),
      .cy       (cy),
      .is_last  (is_last),
      .is_border(is_border)
   );

   // FSM state register
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_n;

   // command latch on accept
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) {it, er, ox, oy} <= '0;
      else if (idle && bus.req) {it, er, ox, oy} <= {bus.item, bus.erase, s_ox, s_oy};

   // registered plot bus and handshake, reflecting the state being entered
   always_ff @(posedge CLOCK_50 or negedge reset_n)
      if (!reset_n) begin
         bus.plot <= 1'b0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.x <= '0;
         bus.y <= '0;
         bus.colour <= '0;
      end else begin
         bus.plot <= drawing;
         bus.busy <= state_n != IDLE;
         bus.done <= state_n == DONE;
         if (drawing) {bus.x, bus.y, bus.colour} <= {nx, ny, col};
      end
endmodule
